if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pipe_reg.sv | 120 ++++++++++++
 tb/tb_if_id_pipe_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a two-entry skid buffer, synchronous flush that
// injects a NOP, and a saturating bubble counter for stall profiling.
// in_ready is taken straight from a flop, so decode's ready never reaches fetch
// combinationally.
module if_id_pipe_reg #(
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Main entry drives out_*; skid entry catches the beat in flight during a stall
  logic              main_valid_q, main_valid_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic [INST_W-1:0] main_inst_q,  main_inst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [INST_W-1:0] skid_inst_q,  skid_inst_d;
  logic [CNT_W-1:0]  bubble_q,     bubble_d;

  logic accept;
  logic take;

  assign accept = in_valid & ~skid_valid_q;
  assign take   = main_valid_q & out_ready;

  // Next-state for the main/skid entries; flush overrides every transition
  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = '0;
      main_inst_d  = NOP_INST;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Empty: load the offered beat straight into main
      if (accept) begin
        main_valid_d = 1'b1;
        main_pc_d    = in_pc;
        main_inst_d  = in_inst;
      end
    end else if (!skid_valid_q) begin
      // One entry held
      if (take && accept) begin
        main_pc_d   = in_pc;
        main_inst_d = in_inst;
      end else if (take) begin
        // Drain: present a NOP but leave out_pc at the last PC
        main_valid_d = 1'b0;
        main_inst_d  = NOP_INST;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_inst_d  = in_inst;
      end
    end else begin
      // Full: in_ready is low, so only a take can move anything
      if (take) begin
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        skid_valid_d = 1'b0;
      end
    end
  end

  // Bubble counter: decode ready with nothing to give it, saturating at all-ones
  always_comb begin
    bubble_d = bubble_q;
    if (!main_valid_q && out_ready && !(&bubble_q)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_inst_q  <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      bubble_q     <= bubble_d;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_pc     = main_pc_q;
  assign out_inst   = main_inst_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a queue-based model of the stage (up to two held
// beats in order) is compared against the DUT every cycle, while directed
// scenarios add literal expectations and random traffic exercises the rest.
module tb_if_id_pipe_reg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          CMAX   = 15;

  logic              clk_50MHz = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 1'b0;

  // Model state: FIFO of held beats, last PC shown, bubble count
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic [31:0] m_last_pc = '0;
  int          m_bubble  = 0;

  if_id_pipe_reg #(
    .PC_W     (PC_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .bubble_cnt (bubble_cnt)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model update on every edge from the inputs that were presented
  always @(posedge clk_50MHz) begin
    if (rst) begin
      m_pc.delete();
      m_inst.delete();
      m_last_pc = '0;
      m_bubble  = 0;
    end else begin
      bit tk, ac;
      if (m_pc.size() == 0 && out_ready && m_bubble < CMAX) m_bubble++;
      tk = (m_pc.size() > 0) && out_ready;
      ac = in_valid && (m_pc.size() < 2);
      if (flush) begin
        m_pc.delete();
        m_inst.delete();
        m_last_pc = '0;
      end else begin
        if (tk) begin
          m_last_pc = m_pc.pop_front();
          void'(m_inst.pop_front());
        end
        if (ac) begin
          m_pc.push_back(in_pc);
          m_inst.push_back(in_inst);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_50MHz) begin
    if (armed) begin
      logic        e_valid;
      logic [31:0] e_pc, e_inst;
      e_valid = (m_pc.size() > 0);
      e_pc    = e_valid ? m_pc[0] : m_last_pc;
      e_inst  = e_valid ? m_inst[0] : NOP;
      chk("mdl_out_valid", 32'(out_valid), 32'(e_valid));
      chk("mdl_in_ready", 32'(in_ready), 32'(m_pc.size() < 2));
      chk("mdl_out_pc", out_pc, e_pc);
      chk("mdl_out_inst", out_inst, e_inst);
      chk("mdl_bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
    end
  end

  // Present inputs for one cycle; returns at the following falling edge
  task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] pc,
                     input logic [31:0] inst, input bit ordy);
    rst = r; flush = f; in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy;
    @(negedge clk_50MHz);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_out_inst"}, out_inst, NOP);
    chk({tag, "_bubble"}, 32'(bubble_cnt), 32'd0);
  endtask

  initial begin
    @(negedge clk_50MHz);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    armed = 1'b1;
    chk_reset_vals("reset");

    // Streaming three beats back to back
    cyc(0, 0, 1, 32'h4, 32'h11, 1);
    chk("stream_pc0", out_pc, 32'h4);
    chk("stream_inst0", out_inst, 32'h11);
    cyc(0, 0, 1, 32'h8, 32'h22, 1);
    chk("stream_pc1", out_pc, 32'h8);
    chk("stream_rdy1", 32'(in_ready), 32'd1);
    cyc(0, 0, 1, 32'hC, 32'h33, 1);
    chk("stream_pc2", out_pc, 32'hC);
    chk("stream_inst2", out_inst, 32'h33);
    chk("stream_bubble", 32'(bubble_cnt), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_drain_pc", out_pc, 32'hC);

    // Stall fill: 0x8 lands in skid, 0xC is held off until release
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h4, 32'h41, 1);
    cyc(0, 0, 1, 32'h8, 32'h42, 0);
    chk("stall_rdy_low", 32'(in_ready), 32'd0);
    chk("stall_pc_hold", out_pc, 32'h4);
    cyc(0, 0, 1, 32'hC, 32'h43, 0);
    cyc(0, 0, 1, 32'hC, 32'h43, 0);
    chk("stall_still_pc4", out_pc, 32'h4);
    cyc(0, 0, 1, 32'hC, 32'h43, 1);
    chk("stall_rel_pc8", out_pc, 32'h8);
    chk("stall_rel_rdy", 32'(in_ready), 32'd1);
    cyc(0, 0, 1, 32'hC, 32'h43, 1);
    chk("stall_rel_pcC", out_pc, 32'hC);
    chk("stall_rel_instC", out_inst, 32'h43);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Flush while full, with a beat offered in the flush cycle
    cyc(0, 0, 1, 32'h20, 32'h51, 1);
    cyc(0, 0, 1, 32'h24, 32'h52, 0);
    cyc(0, 1, 1, 32'h40, 32'h53, 0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_inst", out_inst, NOP);
    chk("flush_pc", out_pc, 32'd0);
    chk("flush_rdy", 32'(in_ready), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("flush_no_0x40", 32'(out_valid), 32'd0);

    // Drain to NOP with bubble counting
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h10, 32'h55, 1);
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_bubble1", 32'(bubble_cnt), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_nop", out_inst, NOP);
    chk("drain_pc_hold", out_pc, 32'h10);
    chk("drain_bubble_hold", 32'(bubble_cnt), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_bubble2", 32'(bubble_cnt), 32'd2);

    // Counter saturation, flush-immune, cleared by reset
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("sat_15", 32'(bubble_cnt), 32'd15);
    cyc(0, 1, 0, 0, 0, 1);
    chk("sat_flush", 32'(bubble_cnt), 32'd15);
    cyc(1, 0, 0, 0, 0, 1);
    chk("sat_rst", 32'(bubble_cnt), 32'd0);

    // Reset while full and stalled
    cyc(0, 0, 1, 32'h60, 32'h61, 0);
    cyc(0, 0, 1, 32'h64, 32'h62, 0);
    chk("rst_full_rdy", 32'(in_ready), 32'd0);
    cyc(1, 0, 1, 32'h68, 32'h63, 0);
    chk_reset_vals("rst_full");
    cyc(0, 0, 1, 32'h70, 32'h64, 1);
    chk("rst_after_pc", out_pc, 32'h70);
    chk("rst_after_valid", 32'(out_valid), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) < 7), $urandom, $urandom, ($urandom_range(0, 9) < 6));
    end
    cyc(0, 0, 0, 0, 0, 1);

    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
